// File: rtl/mdu_if.sv
// mdu_if: operand/control/result bundle between the EX stage and the multiply/divide unit.
//   A, B     : rs / rt operands
//   MDUOp    : operation select (mult, multu, div, divu, mfhi, mflo, mthi, mtlo)
//   start    : one-cycle launch pulse for mult/multu/div/divu
//   busy     : operation in flight
//   HI, LO   : committed HI/LO registers
//   result   : mfhi/mflo read data (combinational), 0 otherwise
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] result;

    modport master (
        output A, B, MDUOp, start,
        input  busy, HI, LO, result
    );

    modport slave (
        input  A, B, MDUOp, start,
        output busy, HI, LO, result
    );
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit holding the HI/LO pair.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mdu_if.slave (operands, op select, start, busy, HI, LO, result)
// The full result is computed when start is accepted and parked in hi_tmp/lo_tmp;
// it is committed to HI/LO after MULT_CYCLES or DIV_CYCLES cycles.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;
    localparam logic [3:0] OP_MTHI  = 4'b0111;
    localparam logic [3:0] OP_MTLO  = 4'b1000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_tmp_q, hi_tmp_d;
    logic [31:0]        lo_tmp_q, lo_tmp_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               dz_q, dz_d;

    // Arithmetic datapath on the live operands (only used in the accept cycle)
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_mag_nz, q_mag, r_mag, q_s, r_s;
    logic [31:0] b_u_nz, q_u, r_u;
    logic        b_zero;

    always_comb begin
        prod_s   = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        prod_u   = {32'd0, bus.A} * {32'd0, bus.B};
        b_zero   = (bus.B == 32'd0);
        // Signed divide via magnitudes; 0x80000000 magnitude stays 2^31 as unsigned
        a_mag    = bus.A[31] ? (32'd0 - bus.A) : bus.A;
        b_mag    = bus.B[31] ? (32'd0 - bus.B) : bus.B;
        // Divisor forced non-zero so the datapath never divides by zero
        b_mag_nz = b_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_mag_nz;
        r_mag    = a_mag % b_mag_nz;
        q_s      = (bus.A[31] ^ bus.B[31]) ? (32'd0 - q_mag) : q_mag;
        r_s      = bus.A[31] ? (32'd0 - r_mag) : r_mag;
        b_u_nz   = b_zero ? 32'd1 : bus.B;
        q_u      = bus.A / b_u_nz;
        r_u      = bus.A % b_u_nz;
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        dz_d     = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.MDUOp >= OP_MULT) && (bus.MDUOp <= OP_DIVU)) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    dz_d    = 1'b0;
                    unique case (bus.MDUOp)
                        OP_MULT: begin
                            {hi_tmp_d, lo_tmp_d} = prod_s;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                        OP_MULTU: begin
                            {hi_tmp_d, lo_tmp_d} = prod_u;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                        OP_DIV: begin
                            hi_tmp_d = r_s;
                            lo_tmp_d = q_s;
                            dz_d     = b_zero;
                            cnt_d    = CNT_W'(DIV_CYCLES);
                        end
                        default: begin
                            hi_tmp_d = r_u;
                            lo_tmp_d = q_u;
                            dz_d     = b_zero;
                            cnt_d    = CNT_W'(DIV_CYCLES);
                        end
                    endcase
                end else if (bus.MDUOp == OP_MTHI) begin
                    hi_d = bus.A;
                end else if (bus.MDUOp == OP_MTLO) begin
                    lo_d = bus.A;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    // Divide by zero leaves HI/LO untouched
                    if (!dz_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    // mf* read port always shows committed HI/LO
    always_comb begin
        unique case (bus.MDUOp)
            OP_MFHI: bus.result = hi_q;
            OP_MFLO: bus.result = lo_q;
            default: bus.result = 32'd0;
        endcase
    end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage of the MIPS pipeline, placed beside `ALU`. It runs `mult`, `multu`, `div` and `divu` over several cycles and holds the HI/LO register pair. It also serves `mfhi`, `mflo`, `mthi` and `mtlo`. The stall unit reads `busy | start` to freeze the pipeline while an MD instruction is in the EX stage and HI/LO is not yet settled. The EX result mux selects between `ALU.result` and `mdu.result`.

## Interface
- `MULT_CYCLES`, 5: cycles from accepted start to HI/LO commit for `mult`/`multu` (≥1).
- `DIV_CYCLES`, 10: cycles from accepted start to HI/LO commit for `div`/`divu` (≥1).

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `A` input 32: operand rs (dividend / multiplicand / mthi-mtlo source).
- `B` input 32: operand rt (divisor / multiplier).
- `MDUOp` input 4: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo; 1001–1111 treated as none.
- `start` input 1: one-cycle pulse, meaningful only with MDUOp 0001–0100.
- `busy` output 1: operation in flight.
- `HI` output 32: committed HI register.
- `LO` output 32: committed LO register.
- `result` output 32: combinational; HI for mfhi, LO for mflo, else 0.

## Operation
- State: IDLE, RUN. Internal registers: `cnt` (wide enough for max(MULT_CYCLES, DIV_CYCLES)), `hi_tmp`, `lo_tmp`, `HI`, `LO`.
- **IDLE, `start`=1, MDUOp ∈ {0001..0100}:** compute the full result from `A`/`B` into `hi_tmp`/`lo_tmp`. Load `cnt` with MULT_CYCLES or DIV_CYCLES. Go to RUN and set `busy`=1.
- **mult:** signed 32×32→64, `{HI,LO}` = product. **multu:** unsigned.
- **div:** signed. LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **divu:** unsigned. LO = quotient, HI = remainder.
- **Divide by zero (B=0):** the operation still runs its full DIV_CYCLES with `busy`. HI/LO are left unchanged at completion.
- **RUN:** `cnt` decrements each cycle. On the edge where `cnt` reaches 1, `HI`/`LO` take `hi_tmp`/`lo_tmp`, `busy`→0, and the state returns to IDLE.
- **mthi / mtlo in IDLE:** HI or LO ← `A` at the edge. `start` is not required.
- **Ignored inputs:**
  - `start` while busy is ignored; the running operation is unaffected.
  - mthi/mtlo while busy are ignored.
  - `start` with any MDUOp outside 0001–0100 is ignored.
- **mfhi/mflo:** `result` always shows the committed HI/LO, never the temporary values. The stall unit must block mf* while `busy | start`.
- Operands are captured at start; later changes to `A`/`B` have no effect.

## Timing
- **Reset:** `busy`=0, `HI`=0, `LO`=0, `cnt`=0, state IDLE. `result` follows from MDUOp (0 for none).
- **Reset mid-operation:** the operation is aborted; all of the above reset values apply at that edge, and no commit occurs.
- **Mult latency:** `start` sampled at edge E0. `busy`=1 from after E0 through edge E0+MULT_CYCLES. At that edge, HI/LO update and `busy` drops. HI/LO are readable in the cycle after E0+MULT_CYCLES.
- **Div latency:** same as mult, with DIV_CYCLES.
- **Back-to-back:** a new `start` is accepted in the first cycle that `busy`=0, i.e. the cycle right after the commit edge.
- **mthi/mtlo:** one-cycle write; the new value appears on HI/LO after the edge.
- **Simultaneous `reset` and `start`:** reset wins.

## Test plan
- **Reset then idle:** `reset` 1 cycle → HI=LO=0, `busy`=0. MDUOp=0110 gives `result`=0.
- **Signed mult:** mult A=0xFFFFFFFE (−2), B=3 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same inputs with multu → HI=0x00000002, LO=0xFFFFFFFA.
- **Signed div:** div A=−7 (0xFFFFFFF9), B=2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Divu and overflow case:** divu A=0xFFFFFFF9, B=2 → LO=0x7FFFFFFC, HI=1. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero and ignored inputs while busy:**
  - Preload HI=0x11, LO=0x22 via mthi/mtlo. Then div with B=0 → busy for 10 cycles, then HI=0x11, LO=0x22.
  - During that busy window, a second `start` and an mtlo A=0x99 → both ignored; no extra busy cycles.
- **Reset mid-operation:** start mult 5×6, then assert `reset` on the 3rd busy cycle → busy=0, HI=LO=0 next cycle, and no commit of 30 follows.
